// File: rtl/rns_reverse_conv_pkg.sv
// rns_reverse_conv_pkg
// Shared definitions for the two-modulus RNS {256, 129} number system.
// Used by the register file, the RNS ALU and the reverse converter so they
// agree on the moduli, the RNS word layout and the converter FSM encoding.
//
// Contents:
//   MOD_A, MOD_B      - the two moduli (256 and 129, coprime)
//   INV_A_MOD_B       - multiplicative inverse of MOD_A modulo MOD_B
//   SCALE_ITERS       - number of doublings that multiply by INV_A_MOD_B
//   R256_* / R129_*   - bit positions of the residues inside an RNS word
//   conv_state_e      - converter FSM states
//   fold_mod_b()      - single conditional subtract of MOD_B
package rns_reverse_conv_pkg;

    localparam int MOD_A       = 256;
    localparam int MOD_B       = 129;
    localparam int INV_A_MOD_B = 64;
    // INV_A_MOD_B is a power of two, so the multiply is done as repeated doubling.
    localparam int SCALE_ITERS = 6;

    localparam int RNS_W    = 16;
    localparam int R256_MSB = 15;
    localparam int R256_LSB = 8;
    localparam int R129_MSB = 7;
    localparam int R129_LSB = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIFF    = 3'd1,
        SCALE   = 3'd2,
        COMBINE = 3'd3,
        DONE    = 3'd4
    } conv_state_e;

    // Reduce a value in 0..255 by one MOD_B step. For inputs below 2*MOD_B
    // (always true for an 8-bit value) this yields the full residue mod MOD_B.
    function automatic logic [7:0] fold_mod_b(input logic [7:0] v);
        logic [7:0] r;
        r = (v >= 8'(MOD_B)) ? (v - 8'(MOD_B)) : v;
        return r;
    endfunction

endpackage

// File: rtl/rns_reverse_conv_mod129_double.sv
// rns_mod129_double
// Combinational modular doubling: dbl_o = (2 * d_i) mod 129.
// Valid for d_i in 0..128; larger inputs give an unspecified value, which the
// converter discards because such operands are flagged as errors.
//
// Ports:
//   d_i    [7:0]  operand residue mod 129
//   dbl_o  [7:0]  doubled residue mod 129
module rns_mod129_double
    import rns_reverse_conv_pkg::*;
(
    input  logic [7:0] d_i,
    output logic [7:0] dbl_o
);

    logic [8:0] dbl_raw;

    assign dbl_raw = {d_i, 1'b0};
    assign dbl_o   = (dbl_raw >= 9'(MOD_B)) ? 8'(dbl_raw - 9'(MOD_B)) : dbl_raw[7:0];

endmodule

// File: rtl/rns_reverse_conv.sv
// rns_reverse_conv
// Converts an RNS word {r256, r129} to its binary value X in 0..33023 with
// mixed-radix CRT: X = r256 + 256*k, k = ((r129 - r256 mod 129) * 64) mod 129.
// The multiply by 64 is six modular doublings, one per SCALE cycle.
// One conversion at a time; result held until the consumer takes it.
//
// Parameters:
//   ERR_CHECK  1: flag r129 > 128 as an error (err=1, bin_out=0); 0: no check
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   in_valid   rns_in carries a word
//   in_ready   converter idle and able to accept a word
//   rns_in     [15:8] r256, [7:0] r129
//   out_valid  bin_out / err carry a result
//   out_ready  consumer takes the result
//   bin_out    converted value
//   err        r129 out of range for the word that produced this result
//
// state   | meaning
// IDLE    | waiting for a word, in_ready=1
// DIFF    | d = (r129 - r256 mod 129) mod 129
// SCALE   | six cycles of d = 2d mod 129 (d * 64 mod 129 = k)
// COMBINE | bin = 256*k + r256, or error result
// DONE    | result presented until out_ready
module rns_reverse_conv
    import rns_reverse_conv_pkg::*;
#(
    parameter bit ERR_CHECK = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] rns_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bin_out,
    output logic        err
);

    conv_state_e state_q, state_d;
    logic [7:0]  r256_q, r256_d;
    logic [7:0]  r129_q, r129_d;
    logic [7:0]  d_q, d_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] bin_q, bin_d;
    logic        err_q, err_d;
    logic        vld_q, vld_d;

    logic [7:0]  a_fold;
    logic [7:0]  d_dbl;

    rns_mod129_double u_double (
        .d_i   (d_q),
        .dbl_o (d_dbl)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            r256_q  <= 8'h00;
            r129_q  <= 8'h00;
            d_q     <= 8'h00;
            cnt_q   <= 3'd0;
            bin_q   <= 16'h0000;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r256_q  <= r256_d;
            r129_q  <= r129_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        r256_d   = r256_q;
        r129_d   = r129_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        err_d    = err_q;
        vld_d    = vld_q;
        in_ready = 1'b0;
        a_fold   = fold_mod_b(r256_q);

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    r256_d  = rns_in[R256_MSB:R256_LSB];
                    r129_d  = rns_in[R129_MSB:R129_LSB];
                    state_d = DIFF;
                end
            end

            DIFF: begin
                // The wrapped 8-bit form is exact: the true result is below 129.
                d_d     = (r129_q >= a_fold) ? (r129_q - a_fold)
                                             : (r129_q + 8'(MOD_B) - a_fold);
                cnt_d   = 3'd0;
                state_d = SCALE;
            end

            SCALE: begin
                d_d   = d_dbl;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(SCALE_ITERS - 1)) begin
                    state_d = COMBINE;
                end
            end

            COMBINE: begin
                if (ERR_CHECK && (r129_q > 8'(MOD_B - 1))) begin
                    bin_d = 16'h0000;
                    err_d = 1'b1;
                end else begin
                    // k < 129 and r256 < 256, so the sum cannot exceed 16 bits.
                    bin_d = {d_q, 8'h00} + {8'h00, r256_q};
                    err_d = 1'b0;
                end
                vld_d   = 1'b1;
                state_d = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_valid = vld_q;
    assign bin_out   = bin_q;
    assign err       = err_q;

endmodule

// File: doc/rns_reverse_conv.md
RNS_REVERSE_CONV -- requirements
Module: rns_reverse_conv

Interface
REQ-001 Parameter ERR_CHECK, default 1: 1 enables the range check on the mod-129 residue; 0 disables it.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  RNS word on rns_in is valid.
REQ-005 in_ready  output  1  converter can accept a word.
REQ-006 rns_in  input  16  RNS register-file word: [15:8] is the mod-256 residue r256, [7:0] is the mod-129 residue r129.
REQ-007 out_valid  output  1  bin_out and err are valid.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 bin_out  output  16  integer value X, 0..33023 (M = 256*129 = 33024).
REQ-010 err  output  1  r129 > 128 was detected (only when ERR_CHECK=1).

Function
REQ-011 Conversion SHALL be mixed-radix CRT: X = r256 + 256*k, with k = ((r129 - (r256 mod 129)) * 64) mod 129; 64 is the inverse of 256 mod 129.
REQ-012 The FSM SHALL have the states IDLE, DIFF, SCALE, COMBINE and DONE.
REQ-013 IDLE: in_ready=1; on in_valid&in_ready, latch rns_in and go to DIFF.
REQ-014 DIFF (1 cycle): a = r256>=129 ? r256-129 : r256; d = r129>=a ? r129-a : r129+129-a (8-bit); clear the 3-bit iteration counter; go to SCALE.
REQ-015 SCALE (exactly 6 cycles): per cycle, t = 2*d (9-bit); d = t>=129 ? t-129 : t; increment the counter; after the 6th cycle go to COMBINE.
REQ-016 COMBINE (1 cycle): bin_out = {d[7:0],8'h00} + r256, 16-bit, no overflow possible; set out_valid=1; go to DONE.
REQ-017 DONE: hold bin_out, err and out_valid stable while out_ready=0; on out_ready=1, clear out_valid and return to IDLE at the same edge.
REQ-018 Latency: out_valid SHALL rise 8 rising edges after the accepting edge.
REQ-019 Throughput: at most one conversion per 9 cycles; in_ready=0 in every state except IDLE; no overlap of conversions.
REQ-020 If ERR_CHECK=1 and r129>128 when latched: err=1 and bin_out=0 at COMBINE; the FSM timing is unchanged.
REQ-021 rns_in changing after acceptance SHALL NOT affect the result in flight.
REQ-022 in_valid asserted in a non-IDLE state SHALL be ignored; no word is latched.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 Asserting reset (low) SHALL immediately set: state=IDLE, in_ready=1, out_valid=0, err=0, bin_out=16'h0000, counter=0, and clear the internal operand registers.
REQ-025 Reset mid-conversion SHALL abort the conversion with no result emitted; the first acceptance after reset deassertion converts normally.

Structure
REQ-026 A shared package SHALL hold: the constants MOD_A=256, MOD_B=129, INV_A_MOD_B=64 and SCALE_ITERS=6, the FSM state enum, and the RNS word field positions [15:8]/[7:0], so the register file, RNS ALU and this block agree.
REQ-027 One sub-module, rns_mod129_double (combinational: 8-bit in -> (2x) mod 129), SHALL be instantiated in SCALE; all other logic is inline.

Verification
REQ-028 Reset, then rns_in=16'h0000 -> bin_out=0, err=0; out_valid rises 8 edges after acceptance.
REQ-029 rns_in={8'd232,8'd97} -> bin_out=1000; rns_in={8'd44,8'd42} -> bin_out=300 (d=127, k=1 path).
REQ-030 rns_in={8'd255,8'd128} -> bin_out=33023 (upper boundary, r256>=129 fold).
REQ-031 Hold out_ready=0 for 5 cycles after out_valid -> bin_out and out_valid stable, in_ready=0 and a new in_valid is ignored; then out_ready=1 -> IDLE, next word accepted.
REQ-032 ERR_CHECK=1, rns_in={8'd10,8'd200} -> err=1, bin_out=0; the following legal word converts with err=0.
REQ-033 Assert reset during SCALE -> out_valid stays 0, all outputs reset; then {8'd232,8'd97} -> 1000.
